// File: rtl/cyclic_lamp_ctrl_if.sv
// cyclic_lamp_ctrl_if: run/pedestrian controls and registered lamp outputs of the junction controller
interface cyclic_lamp_ctrl_if #(parameter int NUM_WAYS = 2);
  localparam int AW = $clog2(NUM_WAYS);
  logic                  enable;
  logic                  ped_req;
  logic [3*NUM_WAYS-1:0] light;
  logic [AW-1:0]         active_way;
  logic [1:0]            phase;
  logic                  walk;
  modport master (output enable, ped_req, input light, active_way, phase, walk);
  modport slave  (input enable, ped_req, output light, active_way, phase, walk);
endinterface

// File: rtl/cyclic_lamp_ctrl.sv
// cyclic_lamp_ctrl: round-robin N-way lamp sequencer GREEN->YELLOW->ALL_RED; define CYCLIC_LAMP_PED_EN for the WALK phase
module cyclic_lamp_ctrl #(
  parameter int NUM_WAYS       = 2,
  parameter int CNT_W          = 8,
  parameter int GREEN_CYCLES   = 8,
  parameter int YELLOW_CYCLES  = 3,
  parameter int ALL_RED_CYCLES = 2,
  parameter int WALK_CYCLES    = 6
) (
  input logic          clock,
  input logic          reset_n,
  cyclic_lamp_ctrl_if.slave bus
);
  localparam int AW = $clog2(NUM_WAYS);
  localparam logic [CNT_W-1:0] G_LD  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] Y_LD  = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] AR_LD = CNT_W'(ALL_RED_CYCLES - 1);
  typedef enum logic [1:0] {ALL_RED = 2'b00, GREEN = 2'b01, YELLOW = 2'b10, WALK = 2'b11} state_e;
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      timer_q, timer_d;
  logic [AW-1:0]         way_q, way_d;
  logic                  started_q, started_d;
  logic [3*NUM_WAYS-1:0] light_q, light_d;
`ifdef CYCLIC_LAMP_PED_EN
  localparam logic [CNT_W-1:0] W_LD = CNT_W'(WALK_CYCLES - 1);
  logic pend_q, pend_d, walk_q, go_walk;
  assign go_walk  = pend_q | bus.ped_req;
  assign bus.walk = walk_q;
`else
  localparam int unused_walk_cycles = WALK_CYCLES;
  logic unused_ped;
  assign unused_ped = bus.ped_req;
  assign bus.walk   = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    way_d     = way_q;
    started_d = started_q;
    light_d   = '0;
`ifdef CYCLIC_LAMP_PED_EN
    pend_d = (bus.enable && state_q != WALK) ? (pend_q | bus.ped_req) : pend_q;
`endif
    if (bus.enable) begin
      if (timer_q != '0) timer_d = timer_q - 1'b1;
      else case (state_q)
        // the very first GREEN after reset belongs to way 0, later ones rotate
        ALL_RED: begin
          state_d   = GREEN;
          timer_d   = G_LD;
          started_d = 1'b1;
          way_d     = (!started_q || way_q == AW'(NUM_WAYS - 1)) ? '0 : way_q + 1'b1;
        end
        GREEN: begin
          state_d = YELLOW;
          timer_d = Y_LD;
        end
`ifdef CYCLIC_LAMP_PED_EN
        YELLOW: begin
          state_d = go_walk ? WALK : ALL_RED;
          timer_d = go_walk ? W_LD : AR_LD;
          if (go_walk) pend_d = 1'b0;
        end
        WALK: begin
          state_d = ALL_RED;
          timer_d = AR_LD;
        end
`else
        YELLOW: begin
          state_d = ALL_RED;
          timer_d = AR_LD;
        end
`endif
        default: begin
          state_d   = ALL_RED;
          timer_d   = AR_LD;
          way_d     = '0;
          started_d = 1'b0;
        end
      endcase
    end
    for (int k = 0; k < NUM_WAYS; k++)
      light_d[3*k +: 3] = (way_d != AW'(k)) ? 3'b100 :
                          (state_d == GREEN) ? 3'b010 :
                          (state_d == YELLOW) ? 3'b001 : 3'b100;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ALL_RED;
      timer_q   <= AR_LD;
      way_q     <= '0;
      started_q <= 1'b0;
      light_q   <= {NUM_WAYS{3'b100}};
`ifdef CYCLIC_LAMP_PED_EN
      pend_q    <= 1'b0;
      walk_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      way_q     <= way_d;
      started_q <= started_d;
      light_q   <= light_d;
`ifdef CYCLIC_LAMP_PED_EN
      pend_q    <= pend_d;
      walk_q    <= (state_d == WALK);
`endif
    end
  end
  assign bus.light      = light_q;
  assign bus.active_way = way_q;
  assign bus.phase      = state_q;
endmodule

// File: tb/tb_cyclic_lamp_ctrl.sv
// tb_cyclic_lamp_ctrl: directed checks of the 2-way sequencer (G=4, Y=2, AR=1, WALK=3)
module tb_cyclic_lamp_ctrl;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int errors = 0;
  int checks = 0;
  int e = 0;
  logic [5:0] prev;
  logic [5:0] exp_light [14] = '{6'o44, 6'o42, 6'o42, 6'o42, 6'o42, 6'o41, 6'o41,
                                 6'o44, 6'o24, 6'o24, 6'o24, 6'o24, 6'o14, 6'o14};
  logic [1:0] exp_phase [14] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2,
                                 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
  logic       exp_way   [14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  cyclic_lamp_ctrl_if #(.NUM_WAYS(2)) bus ();
  cyclic_lamp_ctrl #(
    .NUM_WAYS(2), .CNT_W(8), .GREEN_CYCLES(4), .YELLOW_CYCLES(2),
    .ALL_RED_CYCLES(1), .WALK_CYCLES(3)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus.slave)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
    if (bus.enable && reset_n) e++;
  endtask
  task automatic run_to(input int t);
    for (int i = 0; i < 100 && e < t; i++) step();
    chk("run_to", e, t);
  endtask
  task automatic check_model();
    int p;
    p = e % 14;
    chk("light", bus.light, exp_light[p]);
    chk("phase", bus.phase, exp_phase[p]);
    chk("way", bus.active_way, (e == 0) ? 1'b0 : exp_way[p]);
    chk("walk", bus.walk, 1'b0);
  endtask
  task automatic check_inv();
    int nonred;
    logic [2:0] a, b;
    nonred = 0;
    for (int k = 0; k < 2; k++) begin
      a = prev[3*k +: 3];
      b = bus.light[3*k +: 3];
      if (b != 3'b100) nonred++;
      chk("order", (a == b) || (a == 3'b100 && b == 3'b010) ||
                   (a == 3'b010 && b == 3'b001) || (a == 3'b001 && b == 3'b100), 1);
    end
    chk("one_active", nonred <= 1, 1);
    prev = bus.light;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    e = 0;
    prev = 6'o44;
  endtask
  initial begin
    bus.enable  = 1'b0;
    bus.ped_req = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_light", bus.light, 6'o44);
    chk("rst_phase", bus.phase, 0);
    chk("rst_way", bus.active_way, 0);
    chk("rst_walk", bus.walk, 0);
    reset_n    = 1'b1;
    bus.enable = 1'b1;
    prev       = 6'o44;
    for (int i = 0; i < 17; i++) begin
      step();
      check_model();
      check_inv();
    end
    bus.enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_light", bus.light, 6'o42);
      chk("hold_e", e, 17);
      check_model();
    end
    bus.enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      bus.enable = (i % 9) != 4;
      step();
      check_model();
      check_inv();
    end
    bus.enable = 1'b1;
    for (int i = 0; i < 14 && (e % 14) != 12; i++) step();
    chk("mid_y1", e % 14, 12);
    chk("y1_light", bus.light, 6'o14);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_light", bus.light, 6'o44);
    chk("async_phase", bus.phase, 0);
    chk("async_way", bus.active_way, 0);
    step();
    reset_n = 1'b1;
    e = 0;
    prev = 6'o44;
    for (int i = 0; i < 20; i++) begin
      step();
      check_model();
      check_inv();
    end
`ifdef CYCLIC_LAMP_PED_EN
    do_reset();
    run_to(2);
    bus.ped_req = 1'b1;
    step();
    bus.ped_req = 1'b0;
    run_to(7);
    chk("p4_walk_ph", bus.phase, 3);
    chk("p4_walk", bus.walk, 1);
    chk("p4_red", bus.light, 6'o44);
    run_to(9);
    chk("p4_walk_end", bus.phase, 3);
    run_to(10);
    chk("p4_ar_ph", bus.phase, 0);
    chk("p4_ar_walk", bus.walk, 0);
    run_to(11);
    chk("p4_g1", bus.light, 6'o24);
    chk("p4_g1_way", bus.active_way, 1);
    run_to(17);
    chk("p4_no_walk", bus.phase, 0);
    do_reset();
    run_to(2);
    bus.ped_req = 1'b1;
    run_to(7);
    chk("p5_walk0", bus.phase, 3);
    run_to(10);
    chk("p5_once", bus.phase, 0);
    run_to(11);
    chk("p5_g1", bus.phase, 1);
    run_to(17);
    chk("p5_walk1", bus.phase, 3);
    run_to(20);
    chk("p5_ar", bus.phase, 0);
    run_to(21);
    chk("p5_g0", bus.light, 6'o42);
    chk("p5_g0_way", bus.active_way, 0);
    bus.ped_req = 1'b0;
`else
    do_reset();
    bus.ped_req = 1'b1;
    run_to(7);
    chk("noped_phase", bus.phase, 0);
    chk("noped_walk", bus.walk, 0);
    bus.ped_req = 1'b0;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
